booth_mult: RTL and testbench
=============================

BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: synchronous, active-high clear.
REQ-004 Port start, input, 1 bit: request to begin one multiplication, sampled only in IDLE.
REQ-005 Port multiplicand, input, 16 bits: two's-complement operand M, captured on the start edge.
REQ-006 Port multiplier, input, 16 bits: two's-complement operand Q, captured on the start edge.
REQ-007 Port product, output, 32 bits: signed product, held registered until the next result; drives the data input of the downstream 32-bit result register.
REQ-008 Port load, output, 1 bit: one-cycle strobe meaning product is valid; drives the load input of the downstream register.
REQ-009 Port busy, output, 1 bit: high while in CALC or DONE.

Function
REQ-010 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-011 In IDLE with start=1, the next edge SHALL:
  - capture M and Q
  - clear accumulator A and the Booth bit q_-1
  - load the iteration counter
  - enter CALC.
REQ-012 In IDLE with start=0, the state and product SHALL be held.
REQ-013 Each CALC cycle SHALL perform one radix-2 Booth step, with the action set by {Q[0],q_-1}:
  - 01: A+M
  - 10: A-M
  - 00/11: no add
  - The step ends with an arithmetic right shift of {A,Q,q_-1}.
REQ-014 A SHALL be held at 17 bits, sign-extended, so that M=-32768 never overflows.
REQ-015 After the 16th CALC step, the FSM SHALL register product={A[15:0],Q} and enter DONE.
REQ-016 Latency: if start is sampled at edge k, load SHALL be high from edge k+16 to edge k+17, and the FSM SHALL return to IDLE at edge k+17.
REQ-017 load SHALL be high only in DONE, for exactly one cycle per accepted start.
REQ-018 start SHALL be ignored in CALC and DONE.
REQ-019 If start is held high continuously, the next operation SHALL be accepted at the first IDLE edge (k+17), so a new operation begins every 17 cycles.
REQ-020 Operand changes after the start edge SHALL NOT affect the result in flight.
REQ-021 The result SHALL be the exact 32-bit two's-complement product for all operand pairs; in particular, (-32768)*(-32768) SHALL give 0x40000000.
REQ-022 product SHALL keep its last value in IDLE and CALC, and update only on entry to DONE.

Reset
REQ-023 When reset=1 at an edge, the block SHALL enter IDLE with:
  - product=0, load=0, busy=0
  - A=0, q_-1=0, counter=0.
REQ-024 Reset SHALL take priority over start and over any state, including mid-CALC and DONE; an aborted operation SHALL produce no load pulse.
REQ-025 start sampled in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 With macro BOOTH_RADIX4_EN defined, the block SHALL use radix-4 Booth recoding:
  - 3-bit groups {Q[1:0],q_-1} select 0, ±M or ±2M
  - A is 18 bits
  - each step shifts arithmetically right by 2
  - 8 CALC steps
  - load high from edge k+8 to k+9, and IDLE at k+9.
REQ-027 Without BOOTH_RADIX4_EN, the block SHALL use radix-2 and the 16-step timing of REQ-016.
REQ-028 Both builds SHALL produce identical product values and identical port behaviour apart from latency.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
  - Reset then start, M=3, Q=5: product=0x0000000F, with a single load pulse at edge k+16 (k+8 with radix-4).
  - M=-7 (0xFFF9), Q=6: product=0xFFFFFFD6. Also M=0x8000, Q=0x8000: product=0x40000000. Also M=0x7FFF, Q=0x8000: product=0xC0008000.
  - start held high, alternating operands 2*2 then -1*1: results 0x00000004 and 0xFFFFFFFF, with load pulses exactly 17 cycles apart (9 with radix-4) and no extra pulses.
  - Assert reset at the 5th CALC cycle: load stays 0, product=0, busy=0 on the next edge; a following start with M=10, Q=10 gives 0x00000064.
  - Change operands and pulse start during CALC: result reflects only the original operands, and no second operation starts until IDLE.
  - Downstream check: a 32-bit register with load tied to load and data tied to product holds 0x0000000F from edge k+17 onward.

Source files
------------

// File: rtl/booth_mult.sv
// Sequential signed 16x16 Booth multiplier with an IDLE/CALC/DONE control FSM.
// Define BOOTH_RADIX4_EN for radix-4 recoding (8 steps); the default build is radix-2 (16 steps).
module booth_mult (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic [31:0] product,
    output logic        load,
    output logic        busy
);

`ifdef BOOTH_RADIX4_EN
    localparam int         AW    = 18;
    localparam logic [4:0] STEPS = 5'd8;
`else
    localparam int         AW    = 17;
    localparam logic [4:0] STEPS = 5'd16;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] a_reg, a_next;
    logic [15:0]   q_reg, q_next;
    logic [15:0]   m_reg, m_next;
    logic          qm1_reg, qm1_next;
    logic [4:0]    cnt_reg, cnt_next;
    logic [31:0]   product_reg, product_next;
    logic          load_reg, load_next;

    logic [AW-1:0] m_ext, addend, sum, a_step;
    logic [15:0]   q_step;
    logic          qm1_step;

    // A is wider than M so the +/-M (or +/-2M) addend can never overflow, even for M = -32768.
    assign m_ext = {{(AW-16){m_reg[15]}}, m_reg};

`ifdef BOOTH_RADIX4_EN
    always_comb begin
        addend = '0;
        case ({q_reg[1:0], qm1_reg})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum      = a_reg + addend;
        a_step   = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_step   = {sum[1:0], q_reg[15:2]};
        qm1_step = q_reg[1];
    end
`else
    always_comb begin
        addend = '0;
        case ({q_reg[0], qm1_reg})
            2'b01:   addend = m_ext;
            2'b10:   addend = -m_ext;
            default: addend = '0;
        endcase
        sum      = a_reg + addend;
        a_step   = {sum[AW-1], sum[AW-1:1]};
        q_step   = {sum[0], q_reg[15:1]};
        qm1_step = q_reg[0];
    end
`endif

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        q_next       = q_reg;
        m_next       = m_reg;
        qm1_next     = qm1_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        load_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    m_next     = multiplicand;
                    q_next     = multiplier;
                    a_next     = '0;
                    qm1_next   = 1'b0;
                    cnt_next   = STEPS;
                    state_next = CALC;
                end
            end
            CALC: begin
                a_next   = a_step;
                q_next   = q_step;
                qm1_next = qm1_step;
                cnt_next = cnt_reg - 5'd1;
                if (cnt_reg == 5'd1) begin
                    product_next = {a_step[15:0], q_step};
                    load_next    = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                // The return-to-IDLE edge also accepts a new start, giving back-to-back throughput.
                if (start) begin
                    m_next     = multiplicand;
                    q_next     = multiplier;
                    a_next     = '0;
                    qm1_next   = 1'b0;
                    cnt_next   = STEPS;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            qm1_reg     <= 1'b0;
            cnt_reg     <= '0;
            product_reg <= '0;
            load_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            q_reg       <= q_next;
            m_reg       <= m_next;
            qm1_reg     <= qm1_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            load_reg    <= load_next;
        end
    end

    assign product = product_reg;
    assign load    = load_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed table, randomized ops against a
// plain-arithmetic model, and hand-written multi-cycle corner sequences.
module tb_booth_mult;

`ifdef BOOTH_RADIX4_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 16;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] multiplicand, multiplier;
    logic [31:0] product;
    logic        load, busy;
    logic [31:0] ds_reg;

    int n_checks = 0;
    int n_fail   = 0;

    booth_mult dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .load         (load),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Downstream 32-bit result register fed by load/product.
    always_ff @(posedge clk) begin
        if (reset)     ds_reg <= '0;
        else if (load) ds_reg <= product;
    end

    typedef struct {
        logic [15:0] m;
        logic [15:0] q;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] model(input logic [15:0] m, input logic [15:0] q);
        logic signed [31:0] sm, sq, p;
        sm = {{16{m[15]}}, m};
        sq = {{16{q[15]}}, q};
        p  = sm * sq;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_op(input logic [15:0] m, input logic [15:0] q, input logic [31:0] req, input string name);
        int lat;
        logic [31:0] got;
        lat = -1;
        got = '0;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (load) begin
                lat = c;
                got = product;
                break;
            end
        end
        check({name, " latency"}, 32'(lat), 32'(LAT));
        check({name, " product"}, got, req);
        @(posedge clk);
        #1;
        check({name, " load_low"}, {31'b0, load}, 32'd0);
        check({name, " idle"}, {31'b0, busy}, 32'd0);
        check({name, " downstream"}, ds_reg, req);
        $display("op %s m=%h q=%h product=%h latency=%0d", name, m, q, got, lat);
    endtask

    task automatic count_loads(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (load) n++;
        end
    endtask

    vec_t vecs[7];

    initial begin
        int pulses, t0, t1, nl, lat;
        logic [31:0] p0, p1, got;
        logic [15:0] rm, rq;

        vecs[0] = '{16'd3,    16'd5,    32'h0000000F};
        vecs[1] = '{16'hFFF9, 16'd6,    32'hFFFFFFD6};
        vecs[2] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[3] = '{16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[6] = '{16'h0000, 16'h8123, 32'h00000000};

        reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset product", product, 32'd0);
        check("reset load", {31'b0, load}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));
            if (i == 0) begin
                repeat (5) @(posedge clk);
                #1 check("downstream hold", ds_reg, 32'h0000000F);
            end
        end

        for (int i = 0; i < 20; i++) begin
            rm = 16'($urandom);
            rq = 16'($urandom);
            do_op(rm, rq, model(rm, rq), $sformatf("rand%0d", i));
        end

        // start held high: 2*2 then -1*1 back to back
        @(negedge clk);
        multiplicand = 16'd2; multiplier = 16'd2; start = 1'b1;
        @(posedge clk);
        #1 multiplicand = 16'hFFFF; multiplier = 16'd1;
        pulses = 0; t0 = -1; t1 = -1; p0 = '0; p1 = '0;
        for (int c = 1; c <= 3 * (LAT + 1); c++) begin
            @(posedge clk);
            #1;
            if (c == LAT + 1) start = 1'b0;
            if (load) begin
                if (pulses == 0) begin t0 = c; p0 = product; end
                else if (pulses == 1) begin t1 = c; p1 = product; end
                pulses++;
            end
        end
        check("held pulses", 32'(pulses), 32'd2);
        check("held first time", 32'(t0), 32'(LAT));
        check("held spacing", 32'(t1 - t0), 32'(LAT + 1));
        check("held first product", p0, 32'h00000004);
        check("held second product", p1, 32'hFFFFFFFF);
        $display("op held-start pulses=%0d t0=%0d t1=%0d p0=%h p1=%h", pulses, t0, t1, p0, p1);

        // reset during the 5th CALC cycle aborts the operation
        @(negedge clk);
        multiplicand = 16'h0101; multiplier = 16'h0202; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort load", {31'b0, load}, 32'd0);
        check("abort product", product, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        count_loads(LAT + 3, nl);
        check("abort no load", 32'(nl), 32'd0);
        $display("op reset-abort loads_after=%0d", nl);
        do_op(16'd10, 16'd10, 32'h00000064, "after_abort");

        // operand change and start pulse during CALC are ignored
        @(negedge clk);
        multiplicand = 16'h1234; multiplier = 16'h0056; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 begin multiplicand = 16'hFFFF; multiplier = 16'h7FFF; start = 1'b1; end
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; got = '0;
        for (int c = 5; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (load) begin lat = c; got = product; break; end
        end
        check("midcalc latency", 32'(lat), 32'(LAT));
        check("midcalc product", got, 32'h00061D78);
        @(posedge clk);
        #1 check("midcalc idle", {31'b0, busy}, 32'd0);
        count_loads(LAT + 3, nl);
        check("midcalc no second op", 32'(nl), 32'd0);
        $display("op midcalc-start product=%h latency=%0d", got, lat);

        // start coincident with reset is ignored
        @(negedge clk);
        reset = 1'b1; start = 1'b1; multiplicand = 16'd9; multiplier = 16'd9;
        @(posedge clk);
        #1 begin reset = 1'b0; start = 1'b0; end
        check("reset+start busy", {31'b0, busy}, 32'd0);
        count_loads(LAT + 3, nl);
        check("reset+start no load", 32'(nl), 32'd0);
        $display("op reset-with-start loads=%0d", nl);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
